// File: rtl/bht_btb_predictor.sv
// Direct-mapped tagged BTB with per-entry saturating direction counters.
// Combinational lookup from the IF1 PC; training and mispredict statistics come from EX.
module bht_btb_predictor #(
  parameter int WORD     = 32,
  parameter int ENTRIES  = 64,
  parameter int IDX_BITS = $clog2(ENTRIES),
  parameter int TAG_BITS = 8,
  parameter int CNT_BITS = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [WORD-1:0] lookup_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [WORD-1:0] pred_target,
  input  logic            upd_valid,
  input  logic [WORD-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [WORD-1:0] upd_target,
  input  logic            upd_mispredict,
  output logic [31:0]     mispredict_cnt
);

  localparam int unsigned WT_INT = 1 << (CNT_BITS - 1);
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [CNT_BITS-1:0] CNT_WT  = CNT_BITS'(WT_INT);
  localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_BITS'(WT_INT - 1);
  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);
  localparam int TAG_LO = IDX_BITS + 2;
  localparam int TAG_HI = IDX_BITS + TAG_BITS + 1;

  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_BITS-1:0] tag_q [ENTRIES];
  logic [WORD-3:0]     tgt_q [ENTRIES];
  logic [CNT_BITS-1:0] cnt_q [ENTRIES];
  logic [31:0]         mis_cnt_q;

  logic [IDX_BITS-1:0] lk_idx;
  logic [TAG_BITS-1:0] lk_tag;
  logic [IDX_BITS-1:0] up_idx;
  logic [TAG_BITS-1:0] up_tag;
  logic                up_hit;
  logic [CNT_BITS-1:0] up_cnt;
  logic                unused_bits;

  assign lk_idx = lookup_pc[IDX_BITS+1:2];
  assign lk_tag = lookup_pc[TAG_HI:TAG_LO];
  assign up_idx = upd_pc[IDX_BITS+1:2];
  assign up_tag = upd_pc[TAG_HI:TAG_LO];
  assign unused_bits = ^{upd_pc[WORD-1:TAG_HI+1], upd_pc[1:0], upd_target[1:0]};

  // Lookup reads registered state only, so a same-cycle update is seen next cycle.
  always_comb begin
    pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken  = pred_hit && cnt_q[lk_idx][CNT_BITS-1];
    pred_target = pred_taken ? {tgt_q[lk_idx], 2'b00} : (lookup_pc + WORD'(4));
  end

  always_comb begin
    up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    up_cnt = cnt_q[up_idx];
  end

  // upd_valid is a one-cycle strobe with no back-pressure: the update is consumed
  // on the rising edge where it is high, unless flush or reset takes precedence.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        cnt_q[i] <= CNT_WNT;
      end
    end else if (flush) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        cnt_q[i] <= CNT_WNT;
      end
    end else if (upd_valid) begin
      if (up_hit) begin
        if (upd_taken) begin
          cnt_q[up_idx] <= (up_cnt == CNT_MAX) ? up_cnt : up_cnt + CNT_ONE;
          tgt_q[up_idx] <= upd_target[WORD-1:2];
        end else begin
          cnt_q[up_idx] <= (up_cnt == '0) ? up_cnt : up_cnt - CNT_ONE;
        end
      end else if (upd_taken) begin
        valid_q[up_idx] <= 1'b1;
        tag_q[up_idx]   <= up_tag;
        tgt_q[up_idx]   <= upd_target[WORD-1:2];
        cnt_q[up_idx]   <= CNT_WT;
      end
    end
  end

  // The statistic is independent of the table and survives flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mis_cnt_q <= '0;
    end else if (upd_valid && upd_mispredict && (mis_cnt_q != 32'hFFFF_FFFF)) begin
      mis_cnt_q <= mis_cnt_q + 32'd1;
    end
  end

  assign mispredict_cnt = mis_cnt_q;

endmodule

// File: tb/tb_bht_btb_predictor.sv
// Directed bench for bht_btb_predictor: stimulus pushes expected lookup results,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_bht_btb_predictor;

  localparam logic [31:0] PC_A = 32'h1C00_0010;
  localparam logic [31:0] PC_A4 = 32'h1C00_0014;
  localparam logic [31:0] PC_B = 32'h1C00_0410;
  localparam logic [31:0] PC_B4 = 32'h1C00_0414;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [31:0] lookup_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;
  logic [31:0] mispredict_cnt;

  logic [65:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  bht_btb_predictor dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .lookup_pc     (lookup_pc),
    .pred_hit      (pred_hit),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_taken     (upd_taken),
    .upd_target    (upd_target),
    .upd_mispredict(upd_mispredict),
    .mispredict_cnt(mispredict_cnt)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // scoreboard monitor
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [65:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp("pred_hit", {31'd0, pred_hit}, {31'd0, e[65]});
      cmp("pred_taken", {31'd0, pred_taken}, {31'd0, e[64]});
      cmp("pred_target", pred_target, e[63:32]);
      cmp("mispredict_cnt", mispredict_cnt, e[31:0]);
    end
  end

  // driver tasks
  task automatic push_exp(input logic hit, input logic tk, input logic [31:0] tgt,
                          input logic [31:0] m);
    exp_q.push_back({hit, tk, tgt, m});
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    upd_valid      = 1'b0;
    upd_mispredict = 1'b0;
    upd_taken      = 1'b0;
    flush          = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                     input logic mis);
    upd_valid      = 1'b1;
    upd_pc         = pc;
    upd_taken      = tk;
    upd_target     = tgt;
    upd_mispredict = mis;
  endtask

  // directed stimulus
  initial begin
    rst = 1'b0; flush = 1'b0; lookup_pc = PC_A;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0; upd_mispredict = 1'b0;
    push_exp(0, 0, PC_A4, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    push_exp(0, 0, PC_A4, 0);
    next_cycle();
    lookup_pc = 32'hFFFF_FFFC;
    push_exp(0, 0, 32'h0000_0000, 0);
    next_cycle();
    lookup_pc = PC_A;
    upd(PC_A, 1, 32'h1C00_0100, 1);
    push_exp(0, 0, PC_A4, 0);
    next_cycle();
    push_exp(1, 1, 32'h1C00_0100, 1);

    for (int i = 0; i < 3; i++) begin
      next_cycle();
      upd(PC_A, 1, 32'h1C00_0103, 0);
      push_exp(1, 1, 32'h1C00_0100, 1);
    end
    // counter at 3: walk down through weakly-taken, not-taken and the floor
    next_cycle(); upd(PC_A, 0, 32'h0, 0); push_exp(1, 1, 32'h1C00_0100, 1);
    next_cycle(); upd(PC_A, 0, 32'h0, 0); push_exp(1, 1, 32'h1C00_0100, 1);
    next_cycle(); upd(PC_A, 0, 32'h0, 0); push_exp(1, 0, PC_A4, 1);
    next_cycle(); upd(PC_A, 0, 32'h0, 0); push_exp(1, 0, PC_A4, 1);
    next_cycle(); upd_mispredict = 1'b1; push_exp(1, 0, PC_A4, 1);
    next_cycle(); upd(PC_A, 1, 32'h1C00_0100, 0); push_exp(1, 0, PC_A4, 1);
    next_cycle(); push_exp(1, 0, PC_A4, 1);

    // alias B shares index 4 with a different tag
    next_cycle(); upd(PC_B, 0, 32'h1C00_0200, 0); push_exp(1, 0, PC_A4, 1);
    next_cycle(); push_exp(1, 0, PC_A4, 1);
    next_cycle(); lookup_pc = PC_B; push_exp(0, 0, PC_B4, 1);
    next_cycle(); lookup_pc = PC_A; upd(PC_B, 1, 32'h1C00_0200, 0); push_exp(1, 0, PC_A4, 1);
    next_cycle(); push_exp(0, 0, PC_A4, 1);
    next_cycle(); lookup_pc = PC_B; push_exp(1, 1, 32'h1C00_0200, 1);

    // same-cycle allocate has no bypass
    next_cycle(); lookup_pc = PC_A; upd(PC_A, 1, 32'h1C00_0300, 0); push_exp(0, 0, PC_A4, 1);
    next_cycle(); push_exp(1, 1, 32'h1C00_0300, 1);

    // flush beats a same-cycle update
    next_cycle(); flush = 1'b1; upd(PC_A, 1, 32'h1C00_0400, 0); push_exp(1, 1, 32'h1C00_0300, 1);
    next_cycle(); push_exp(0, 0, PC_A4, 1);
    next_cycle(); upd(PC_A, 1, 32'h1C00_0500, 1); push_exp(0, 0, PC_A4, 1);
    next_cycle(); push_exp(1, 1, 32'h1C00_0500, 2);

    // mispredict counter saturation
    next_cycle();
    force dut.mis_cnt_q = 32'hFFFF_FFFE;
    #1 release dut.mis_cnt_q;
    upd(PC_A, 1, 32'h1C00_0500, 1); push_exp(1, 1, 32'h1C00_0500, 32'hFFFF_FFFE);
    next_cycle(); upd(PC_A, 1, 32'h1C00_0500, 1); push_exp(1, 1, 32'h1C00_0500, 32'hFFFF_FFFF);
    next_cycle(); upd(PC_A, 1, 32'h1C00_0500, 1); push_exp(1, 1, 32'h1C00_0500, 32'hFFFF_FFFF);
    next_cycle(); push_exp(1, 1, 32'h1C00_0500, 32'hFFFF_FFFF);

    // asynchronous reset mid-cycle, during an update
    next_cycle();
    upd(PC_A, 1, 32'h1C00_0600, 1);
    #2 rst = 1'b0;
    push_exp(0, 0, PC_A4, 0);
    next_cycle();
    rst = 1'b1;
    push_exp(0, 0, PC_A4, 0);
    next_cycle();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bht_btb_predictor.md
Name: bht_btb_predictor

Overview:
- Parametrised branch predictor that replaces the fixed single 2-bit counter in the fetch path.
- Combines a direct-mapped, tagged BTB with per-entry saturating N-bit direction counters.
- Lookup is made with the IF1 PC. The result drives the predicted-branch and predicted-PC inputs of IF0.
- Training comes from the EX branch resolution, which also supplies a mispredict statistic.

Parameters:
- WORD, 32, PC/target width in bits.
- ENTRIES, 64, number of BTB/BHT entries; power of two, at least 4.
- IDX_BITS, log2(ENTRIES), index width; index = pc[IDX_BITS+1:2].
- TAG_BITS, 8, tag width; tag = pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2].
- CNT_BITS, 2, direction counter width, 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous invalidate of all entries.
- lookup_pc  in  WORD  IF1 PC.
- pred_hit  out  1  valid entry with matching tag at the lookup index.
- pred_taken  out  1  predicted taken.
- pred_target  out  WORD  predicted next PC.
- upd_valid  in  1  EX resolves a branch this cycle.
- upd_pc  in  WORD  PC of the resolved branch.
- upd_taken  in  1  actual direction.
- upd_target  in  WORD  actual taken target.
- upd_mispredict  in  1  EX detected a misprediction.
- mispredict_cnt  out  32  saturating count of mispredicts.

Behaviour:
- Storage, per entry: valid (1), tag (TAG_BITS), target (WORD-2; low 2 bits implied 0), cnt (CNT_BITS).
- Lookup is combinational from registered state, with zero-cycle latency.
  - pred_hit = valid[idx] && tag[idx]==lookup tag.
  - pred_taken = pred_hit && cnt[idx][CNT_BITS-1].
  - pred_target = pred_taken ? {target[idx],2'b00} : lookup_pc+4. Addition wraps modulo 2^WORD.
- Update happens on the rising edge when upd_valid=1, with index and tag taken from upd_pc.
  - Hit, taken: cnt increments and saturates at 2^CNT_BITS-1; target <= upd_target[WORD-1:2].
  - Hit, not taken: cnt decrements and saturates at 0; target is unchanged.
  - Miss, taken: allocate/overwrite the entry. valid=1, tag written, target written, cnt = 2^(CNT_BITS-1) (weakly taken).
  - Miss, not taken: no state change.
- Simultaneous lookup and update to the same index: the lookup returns the pre-update value. There is no bypass; the new value is visible the next cycle.
- flush=1: on the next edge all valid bits clear and counters reset to 2^(CNT_BITS-1)-1.
  - flush has priority over an upd_valid in the same cycle; that update is dropped.
  - mispredict_cnt is not affected by flush.
- mispredict_cnt increments by 1 on each edge where upd_valid && upd_mispredict. It holds at 0xFFFFFFFF.
- upd_mispredict with upd_valid=0 is ignored.
- Reset (rst=0), asynchronous and immediate:
  - all valid=0;
  - all cnt = 2^(CNT_BITS-1)-1 (weakly not-taken);
  - targets and tags are don't-care but must be deterministic (0);
  - mispredict_cnt=0.
  - Resulting outputs: pred_hit=0, pred_taken=0, pred_target=lookup_pc+4.
- Reset asserted mid-update: the update is lost; state equals the post-reset state.
- CNT_BITS=1 degenerates to last-outcome prediction: taken sets cnt=1, not taken sets cnt=0. Allocation writes 1.
- upd_target low bits are ignored.

Test Plan (defaults throughout; PC A=0x1C000010 → idx 4, tag 0x00):
- Reset, then lookup_pc=A → pred_hit=0, pred_taken=0, pred_target=0x1C000014, mispredict_cnt=0.
- Update A taken to 0x1C000100 with mispredict=1, then lookup A → hit=1, taken=1 (cnt=2), target=0x1C000100, mispredict_cnt=1.
- Counter saturation at A:
  - 3 taken updates → cnt=3;
  - then 1 not-taken → cnt=2, still predicts taken;
  - 2nd not-taken → cnt=1 → pred_taken=0, pred_target=0x1C000014;
  - 2 more not-taken → cnt floors at 0.
- Alias and no-allocate:
  - with A allocated, update B=0x1C000410 (idx 4, tag 0x04) not taken → A entry unchanged, lookup A still hits;
  - update B taken → entry replaced, lookup A → hit=0.
- Same-cycle hazard and flush:
  - lookup A in the same cycle as an update that allocates A → hit=0 that cycle, hit=1 next cycle;
  - assert flush together with upd_valid → next cycle lookup A hit=0, and the dropped update has no effect.
- mispredict_cnt saturation: force the count to 0xFFFFFFFE and apply 3 mispredicts → 0xFFFFFFFF held. Async reset mid-cycle → 0 immediately.
